n1_sbus_ram: RTL

//  Stack bus target for the N1 core: pipelined wishbone slave behind sbus_* that holds the

---
 rtl/n1_sbus_ram_pkg.sv | 13 +
 rtl/n1_sbus_ram_if.sv | 30 +++
 rtl/n1_sbus_ram_bank.sv | 29 ++
 rtl/n1_sbus_ram.sv | 149 ++++++++++++++
 4 files changed

// File: rtl/n1_sbus_ram_pkg.sv
// n1_sbus_pkg: shared constants and FSM state encoding for the N1 stack-bus RAM.
package n1_sbus_pkg;

   localparam int WORD_WIDTH = 16;
   localparam int CNT_WIDTH  = 4;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      WAIT = 2'd1,
      RESP = 2'd2
   } sbus_state_e;

endpackage

// File: rtl/n1_sbus_ram_if.sv
// n1_sbus_ram_if: pipelined wishbone stack-bus signals between the N1 core (master)
// and the stack RAM (slave). Suffixes are from the slave's point of view.
interface n1_sbus_ram_if
   import n1_sbus_pkg::*;
#(
   parameter int SP_WIDTH = 12
);
   logic                  cyc_i;
   logic                  stb_i;
   logic                  we_i;
   logic [SP_WIDTH-1:0]   adr_i;
   logic [WORD_WIDTH-1:0] dat_i;
   logic                  tga_ps_i;
   logic                  tga_rs_i;
   logic                  ack_o;
   logic                  err_o;
   logic                  rty_o;
   logic                  stall_o;
   logic [WORD_WIDTH-1:0] dat_o;

   modport master (
      output cyc_i, stb_i, we_i, adr_i, dat_i, tga_ps_i, tga_rs_i,
      input  ack_o, err_o, rty_o, stall_o, dat_o
   );

   modport slave (
      input  cyc_i, stb_i, we_i, adr_i, dat_i, tga_ps_i, tga_rs_i,
      output ack_o, err_o, rty_o, stall_o, dat_o
   );
endinterface

// File: rtl/n1_sbus_ram_bank.sv
// n1_sbus_ram_bank: single-port synchronous RAM, read-before-write, registered read.
// Contents are deliberately not reset so the array maps onto block RAM.
module n1_sbus_ram_bank
   import n1_sbus_pkg::*;
#(
   parameter int SP_WIDTH = 12
) (
   input  logic                  clk_i,
   input  logic                  en_i,
   input  logic                  we_i,
   input  logic [SP_WIDTH-1:0]   adr_i,
   input  logic [WORD_WIDTH-1:0] dat_i,
   output logic [WORD_WIDTH-1:0] dat_o
);
   logic [WORD_WIDTH-1:0] mem_q [0:(2**SP_WIDTH)-1];
   logic [WORD_WIDTH-1:0] rd_q;

   // Enabled access: optional write, old contents always land in the read register
   always_ff @(posedge clk_i) begin
      if (en_i) begin
         if (we_i) begin
            mem_q[adr_i] <= dat_i;
         end
         rd_q <= mem_q[adr_i];
      end
   end

   assign dat_o = rd_q;
endmodule

// File: rtl/n1_sbus_ram.sv
// n1_sbus_ram: stack-bus slave holding the N1 parameter and return stacks in two banks.
// Optional feature macro: N1_SBUS_RAM_BOUNDS_EN (address limit checking per stack).
// The RAM access happens on the edge that enters RESP, so ack/err/read data all
// appear together in the RESP cycle; abandoning the cycle before that edge leaves
// memory untouched.
module n1_sbus_ram
   import n1_sbus_pkg::*;
#(
   parameter int          SP_WIDTH    = 12,
   parameter int          WAIT_CYCLES = 0,
   parameter int unsigned PS_LIMIT    = 'hFFF,
   parameter int unsigned RS_LIMIT    = 'hFFF
) (
   input  logic            clk_i,
   input  logic            async_rst_i,
   n1_sbus_ram_if.slave    sbus
);
   localparam logic [1:0] S_IDLE = IDLE;
   localparam logic [1:0] S_WAIT = WAIT;
   localparam logic [1:0] S_RESP = RESP;
   localparam bit ZERO_WAIT = (WAIT_CYCLES == 0);
   localparam logic [CNT_WIDTH-1:0] CNT_LOAD =
      CNT_WIDTH'((WAIT_CYCLES > 0) ? WAIT_CYCLES - 1 : 0);
`ifdef N1_SBUS_RAM_BOUNDS_EN
   localparam bit BOUNDS_ON = 1'b1;
`else
   localparam bit BOUNDS_ON = 1'b0;
`endif

   logic [1:0]            state_q, state_d;
   logic [CNT_WIDTH-1:0]  cnt_q, cnt_d;
   logic                  we_q, ps_q, rs_q;
   logic [SP_WIDTH-1:0]   adr_q;
   logic [WORD_WIDTH-1:0] wdat_q;
   logic                  ack_q, err_q, rd_ack_q, sel_rs_q;
   logic [WORD_WIDTH-1:0] rdat_q;

   logic                  stall, accept, fire;
   logic                  f_we, f_ps, f_rs, f_err, tag_err, bnd_err;
   logic [SP_WIDTH-1:0]   f_adr;
   logic [WORD_WIDTH-1:0] f_dat, ps_rd, rs_rd, dat_out;

   assign stall  = (state_q == S_WAIT);
   assign accept = sbus.cyc_i & sbus.stb_i & ~stall;

   // With no wait states the access is performed straight from the bus; otherwise
   // from the fields captured at accept time, after the countdown expires.
   assign fire  = ZERO_WAIT ? accept
                            : (stall & sbus.cyc_i & (cnt_q == '0));
   assign f_we  = ZERO_WAIT ? sbus.we_i     : we_q;
   assign f_adr = ZERO_WAIT ? sbus.adr_i    : adr_q;
   assign f_dat = ZERO_WAIT ? sbus.dat_i    : wdat_q;
   assign f_ps  = ZERO_WAIT ? sbus.tga_ps_i : ps_q;
   assign f_rs  = ZERO_WAIT ? sbus.tga_rs_i : rs_q;

   assign tag_err = ~(f_ps ^ f_rs);
   assign bnd_err = BOUNDS_ON &
                    ((f_ps & ~f_rs & (32'(f_adr) > PS_LIMIT)) |
                     (f_rs & ~f_ps & (32'(f_adr) > RS_LIMIT)));
   assign f_err   = tag_err | bnd_err;

   n1_sbus_ram_bank #(.SP_WIDTH(SP_WIDTH)) u_ps_bank (
      .clk_i (clk_i),
      .en_i  (fire & f_ps & ~f_err),
      .we_i  (f_we),
      .adr_i (f_adr),
      .dat_i (f_dat),
      .dat_o (ps_rd)
   );

   n1_sbus_ram_bank #(.SP_WIDTH(SP_WIDTH)) u_rs_bank (
      .clk_i (clk_i),
      .en_i  (fire & f_rs & ~f_err),
      .we_i  (f_we),
      .adr_i (f_adr),
      .dat_i (f_dat),
      .dat_o (rs_rd)
   );

   // Read data is shown only in a read-ack cycle, otherwise the last shown value is held
   assign dat_out = rd_ack_q ? (sel_rs_q ? rs_rd : ps_rd) : rdat_q;

   // Next-state and wait counter: accept from IDLE or RESP, count down in WAIT
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      case (state_q)
         S_IDLE, S_RESP: begin
            if (accept) begin
               state_d = ZERO_WAIT ? S_RESP : S_WAIT;
               cnt_d   = CNT_LOAD;
            end else begin
               state_d = S_IDLE;
            end
         end
         S_WAIT: begin
            if (!sbus.cyc_i) begin
               state_d = S_IDLE;
            end else if (cnt_q == '0) begin
               state_d = S_RESP;
            end else begin
               cnt_d = cnt_q - 1'b1;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   // Registered FSM, captured request fields and response flags
   always_ff @(posedge clk_i or negedge async_rst_i) begin
      if (!async_rst_i) begin
         state_q  <= S_IDLE;
         cnt_q    <= '0;
         we_q     <= 1'b0;
         ps_q     <= 1'b0;
         rs_q     <= 1'b0;
         adr_q    <= '0;
         wdat_q   <= '0;
         ack_q    <= 1'b0;
         err_q    <= 1'b0;
         rd_ack_q <= 1'b0;
         sel_rs_q <= 1'b0;
         rdat_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         if (accept) begin
            we_q   <= sbus.we_i;
            ps_q   <= sbus.tga_ps_i;
            rs_q   <= sbus.tga_rs_i;
            adr_q  <= sbus.adr_i;
            wdat_q <= sbus.dat_i;
         end
         ack_q    <= fire & ~f_err;
         err_q    <= fire & f_err;
         rd_ack_q <= fire & ~f_err & ~f_we;
         if (fire) begin
            sel_rs_q <= f_rs;
         end
         rdat_q <= dat_out;
      end
   end

   assign sbus.ack_o   = ack_q;
   assign sbus.err_o   = err_q;
   assign sbus.rty_o   = 1'b0;
   assign sbus.stall_o = stall;
   assign sbus.dat_o   = dat_out;
endmodule
